// File: rtl/dma_chan_sched_if.sv
// Channel/core bus bundle for the round-robin DMA channel scheduler.
// master: scheduler side; slave: channel front-end plus dma_core side.
interface dma_chan_sched_if #(
    parameter int NUM_CHAN       = 4,
    parameter int DMA_NUM_DESC   = 8,
    parameter int CHAN_IDX_WIDTH = $clog2(NUM_CHAN)
);
    logic [NUM_CHAN-1:0]              chan_req;
    logic [NUM_CHAN*DMA_NUM_DESC-1:0] chan_desc_mask;
    logic [NUM_CHAN-1:0]              chan_grant;
    logic [NUM_CHAN-1:0]              chan_done;
    logic [NUM_CHAN-1:0]              chan_err;
    logic [1:0]                       chan_err_code;
    logic                             sched_busy;
    logic [CHAN_IDX_WIDTH-1:0]        sched_cur_chan;
    logic [DMA_NUM_DESC-1:0]          core_desc_enable;
    logic                             core_start;
    logic                             core_done;
    logic                             core_err;
    logic [1:0]                       core_err_type;
    logic                             core_err_clr;

    modport master (
        input  chan_req, chan_desc_mask,
        input  core_done, core_err, core_err_type,
        output chan_grant, chan_done, chan_err, chan_err_code,
        output sched_busy, sched_cur_chan,
        output core_desc_enable, core_start, core_err_clr
    );

    modport slave (
        output chan_req, chan_desc_mask,
        output core_done, core_err, core_err_type,
        input  chan_grant, chan_done, chan_err, chan_err_code,
        input  sched_busy, sched_cur_chan,
        input  core_desc_enable, core_start, core_err_clr
    );
endinterface

// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one dma_core between NUM_CHAN channels.
// Optional WAIT watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_chan_sched #(
    parameter int NUM_CHAN       = 4,
    parameter int DMA_NUM_DESC   = 8,
    parameter int CHAN_IDX_WIDTH = $clog2(NUM_CHAN)
`ifdef DMA_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_WIDTH  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    dma_chan_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_FIN,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [CHAN_IDX_WIDTH-1:0] cur_q, cur_d;
    logic [NUM_CHAN-1:0]       grant_q, grant_d;
    logic [NUM_CHAN-1:0]       done_q, done_d;
    logic [NUM_CHAN-1:0]       err_q, err_d;
    logic [1:0]                code_q, code_d;
    logic [DMA_NUM_DESC-1:0]   desc_q, desc_d;
    logic                      start_q, start_d;
    logic                      clr_q, clr_d;
    logic                      core_done_q, core_done_d;

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]  to_cnt_q, to_cnt_d;
`endif

    logic [DMA_NUM_DESC-1:0]   masks [NUM_CHAN];
    logic [DMA_NUM_DESC-1:0]   win_mask;
    logic [CHAN_IDX_WIDTH-1:0] win;
    logic                      win_vld;
    logic [CHAN_IDX_WIDTH:0]   sum;
    logic                      done_edge;
    logic [1:0]                core_code;

    function automatic logic [NUM_CHAN-1:0] onehot(
        input logic [CHAN_IDX_WIDTH-1:0] idx
    );
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            masks[c] = bus.chan_desc_mask[c*DMA_NUM_DESC +: DMA_NUM_DESC];
        end
    end

    // Walk from furthest to nearest so the nearest requester after cur wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        for (int k = NUM_CHAN; k >= 1; k--) begin
            sum = {1'b0, cur_q} + (CHAN_IDX_WIDTH+1)'(k);
            if (sum >= (CHAN_IDX_WIDTH+1)'(NUM_CHAN)) begin
                sum = sum - (CHAN_IDX_WIDTH+1)'(NUM_CHAN);
            end
            if (bus.chan_req[sum[CHAN_IDX_WIDTH-1:0]]) begin
                win     = sum[CHAN_IDX_WIDTH-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign win_mask    = masks[win];
    assign core_done_d = bus.core_done;
    assign done_edge   = bus.core_done & ~core_done_q;
    assign core_code   = (bus.core_err_type == 2'b10) ? 2'b10
                                                      : {1'b0, bus.core_err_type[0]};

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        grant_d = grant_q;
        desc_d  = desc_q;
        done_d  = '0;
        err_d   = '0;
        code_d  = 2'b00;
        start_d = 1'b0;
        clr_d   = 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|bus.chan_req) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_vld) begin
                    cur_d  = win;
                    desc_d = win_mask;
                    if (win_mask == '0) begin
                        state_d = S_ERR;
                        err_d   = onehot(win);
                        code_d  = 2'b10;
                    end else begin
                        state_d = S_START;
                        grant_d = onehot(win);
                        start_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.core_err) begin
                    state_d = S_ERR;
                    err_d   = onehot(cur_q);
                    code_d  = core_code;
                    clr_d   = 1'b1;
                    grant_d = '0;
                    desc_d  = '0;
                end else if (done_edge) begin
                    state_d = S_FIN;
                    done_d  = onehot(cur_q);
                    grant_d = '0;
                    desc_d  = '0;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (to_cnt_q == '1) begin
                    state_d = S_ERR;
                    err_d   = onehot(cur_q);
                    code_d  = 2'b11;
                    clr_d   = 1'b1;
                    grant_d = '0;
                    desc_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= CHAN_IDX_WIDTH'(NUM_CHAN - 1);
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            code_q      <= 2'b00;
            desc_q      <= '0;
            start_q     <= 1'b0;
            clr_q       <= 1'b0;
            core_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            desc_q      <= desc_d;
            start_q     <= start_d;
            clr_q       <= clr_d;
            core_done_q <= core_done_d;
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign bus.chan_grant       = grant_q;
    assign bus.chan_done        = done_q;
    assign bus.chan_err         = err_q;
    assign bus.chan_err_code    = code_q;
    assign bus.sched_busy       = (state_q != S_IDLE);
    assign bus.sched_cur_chan   = cur_q;
    assign bus.core_desc_enable = desc_q;
    assign bus.core_start       = start_q;
    assign bus.core_err_clr     = clr_q;
endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed plus randomized bench for dma_chan_sched (default build).
// Reference model: rotation search over requests and a table of error codes.
module tb_dma_chan_sched;
    localparam int NC = 4;
    localparam int ND = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dma_chan_sched_if #(
        .NUM_CHAN(NC), .DMA_NUM_DESC(ND), .CHAN_IDX_WIDTH(CW)
    ) bus ();

    dma_chan_sched #(
        .NUM_CHAN(NC), .DMA_NUM_DESC(ND), .CHAN_IDX_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int ncmp  = 0;
    int nfail = 0;
    int last_win;
    logic [ND-1:0] mref [NC];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] ohf(input int c);
        logic [NC-1:0] one;
        one = 1;
        return one << c;
    endfunction

    function automatic int model_win(input logic [NC-1:0] req);
        for (int k = 1; k <= NC; k++) begin
            if (req[(last_win + k) % NC]) return (last_win + k) % NC;
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_code(input logic [1:0] t);
        case (t)
            2'd0: return 2'd0;
            2'd1: return 2'd1;
            2'd2: return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    task automatic set_masks();
        for (int c = 0; c < NC; c++) bus.chan_desc_mask[c*ND +: ND] = mref[c];
    endtask

    // kind 0: done edge; 1: error together with done; 2: error alone
    task automatic run_txn(input logic [NC-1:0] req, input int kind,
                           input int dly_in, input logic [1:0] etype,
                           input bit keep_done, input bit scramble);
        int w;
        int dly;
        bit done_high;
        logic [ND-1:0] expm;
        dly = dly_in;
        set_masks();
        bus.chan_req = req;
        w = model_win(req);
        @(negedge clk);
        chk("arb_busy", 32'(bus.sched_busy), 32'd1);
        chk("arb_nostart", 32'(bus.core_start), 32'd0);
        @(negedge clk);
        chk("cur_chan", 32'(bus.sched_cur_chan), 32'(w));
        last_win = w;
        if (mref[w] == '0) begin
            chk("empty_err", 32'(bus.chan_err), 32'(ohf(w)));
            chk("empty_code", 32'(bus.chan_err_code), 32'd2);
            chk("empty_noclr", 32'(bus.core_err_clr), 32'd0);
            chk("empty_nostart", 32'(bus.core_start), 32'd0);
            chk("empty_nogrant", 32'(bus.chan_grant), 32'd0);
        end else begin
            expm = mref[w];
            chk("start", 32'(bus.core_start), 32'd1);
            chk("desc_en", 32'(bus.core_desc_enable), 32'(expm));
            chk("grant", 32'(bus.chan_grant), 32'(ohf(w)));
            done_high = bus.core_done;
            if (done_high && dly < 2) dly = 2;
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("wait_nostart", 32'(bus.core_start), 32'd0);
                chk("wait_grant", 32'(bus.chan_grant), 32'(ohf(w)));
                chk("wait_desc", 32'(bus.core_desc_enable), 32'(expm));
                chk("wait_nodone", 32'(bus.chan_done | bus.chan_err), 32'd0);
                if (scramble) begin
                    for (int c = 0; c < NC; c++) mref[c] = ND'($urandom);
                    set_masks();
                    bus.chan_req = NC'($urandom_range(1, (1 << NC) - 1));
                end
                if (i == 0 && done_high) bus.core_done = 1'b0;
                if (i == dly - 1) begin
                    if (kind == 0) begin
                        bus.core_done = 1'b1;
                    end else begin
                        bus.core_err      = 1'b1;
                        bus.core_err_type = etype;
                        bus.core_done     = (kind == 1);
                    end
                end
            end
            @(negedge clk);
            if (kind == 0) begin
                chk("fin_done", 32'(bus.chan_done), 32'(ohf(w)));
                chk("fin_noerr", 32'(bus.chan_err), 32'd0);
                chk("fin_grant", 32'(bus.chan_grant), 32'd0);
                chk("fin_desc", 32'(bus.core_desc_enable), 32'd0);
            end else begin
                chk("err_pulse", 32'(bus.chan_err), 32'(ohf(w)));
                chk("err_code", 32'(bus.chan_err_code), 32'(model_code(etype)));
                chk("err_clr", 32'(bus.core_err_clr), 32'd1);
                chk("err_nodone", 32'(bus.chan_done), 32'd0);
                chk("err_grant", 32'(bus.chan_grant), 32'd0);
            end
            bus.core_err = 1'b0;
            if (!keep_done) bus.core_done = 1'b0;
        end
        @(negedge clk);
        chk("idle_busy", 32'(bus.sched_busy), 32'd0);
        chk("idle_pulses", 32'(bus.chan_done | bus.chan_err), 32'd0);
        chk("idle_clr", 32'(bus.core_err_clr), 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.chan_req       = '0;
        bus.chan_desc_mask = '0;
        bus.core_done      = 1'b0;
        bus.core_err       = 1'b0;
        bus.core_err_type  = 2'b00;
        last_win           = NC - 1;
        for (int c = 0; c < NC; c++) mref[c] = ND'(8'h11 << c);
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus.chan_grant), 32'd0);
        chk("rst_busy", 32'(bus.sched_busy), 32'd0);
        chk("rst_cur", 32'(bus.sched_cur_chan), 32'(NC - 1));
        chk("rst_desc", 32'(bus.core_desc_enable), 32'd0);
        chk("rst_start", 32'(bus.core_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_noreq", 32'(bus.sched_busy), 32'd0);

        // all channels requesting: rotation 0,1,2,3,0
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 0, 1 + n % 3, 2'b00, 0, 0);

        mref[0] = 8'h03;
        run_txn(4'b0001, 0, 1, 2'b00, 0, 0);

        mref[2] = 8'h00;
        run_txn(4'b0100, 0, 1, 2'b00, 0, 0);

        mref[1] = 8'h5a;
        run_txn(4'b0010, 1, 2, 2'b01, 0, 0);

        mref[3] = 8'h0f;
        run_txn(4'b1000, 0, 1, 2'b00, 1, 0);
        run_txn(4'b1000, 0, 3, 2'b00, 0, 0);

        for (int n = 0; n < 60; n++) begin
            for (int c = 0; c < NC; c++) begin
                mref[c] = ($urandom_range(0, 3) == 0) ? '0 : ND'($urandom);
            end
            run_txn(NC'($urandom_range(1, (1 << NC) - 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 5)),
                    2'($urandom), 1'($urandom), 1'($urandom));
        end

        // asynchronous reset in the middle of WAIT
        bus.core_done = 1'b0;
        for (int c = 0; c < NC; c++) mref[c] = 8'hff;
        set_masks();
        bus.chan_req = 4'b0110;
        repeat (3) @(negedge clk);
        chk("pre_rst_grant", 32'(|bus.chan_grant), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.chan_grant), 32'd0);
        chk("arst_busy", 32'(bus.sched_busy), 32'd0);
        chk("arst_desc", 32'(bus.core_desc_enable), 32'd0);
        chk("arst_cur", 32'(bus.sched_cur_chan), 32'(NC - 1));
        @(negedge clk);
        rst_n    = 1'b1;
        last_win = NC - 1;
        run_txn(4'b1111, 0, 2, 2'b00, 0, 0);
        chk("post_rst_first", 32'(bus.sched_cur_chan), 32'd0);

        bus.chan_req = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
